uart_tx_arbiter: RTL and testbench

Shares the single UART transmit byte stream between several on-chip requesters (CPU console store path, debug monitor, trace/printf units) at message granularity, so characters from different sources never interleave. It sits between the requesters and the UART transmitter's FIFO write port. It grants one requester at a time with round-robin fairness, forwards its bytes under FIFO back-pressure, and releases the grant on end-of-message or on an idle timeout.

---
 rtl/uart_tx_arbiter_pkg.sv | 18 +
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 102 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state type, requester
// bound, end-of-line byte and an index-width helper.
package uart_tx_arbiter_pkg;

    localparam int unsigned MAX_REQ = 16;
    localparam logic [7:0]  NL_BYTE = 8'h0A;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } arb_state_e;

    // Index width that stays legal (>= 1 bit) for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and FIFO-side signals of the UART transmit arbiter.
// The arbiter uses the slave view; requesters and the FIFO model use master.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]      req_valid_i;
    logic [NUM_REQ-1:0][7:0] req_data_i;
    logic [NUM_REQ-1:0]      req_last_i;
    logic [NUM_REQ-1:0]      req_ready_o;
    logic                    tx_full_i;
    logic                    tx_we_o;
    logic [7:0]              tx_data_o;
    logic [NUM_REQ-1:0]      grant_o;
    logic                    busy_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, tx_full_i,
        output req_ready_o, tx_we_o, tx_data_o, grant_o, busy_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i, tx_full_i,
        input  req_ready_o, tx_we_o, tx_data_o, grant_o, busy_o
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr_i,
// wrapping around, as a one-hot grant plus its index.
module rr_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cidx;
        cand  = 0;
        cidx  = '0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr_i) + k) % NUM_REQ;
            cidx = IDX_W'(cand);
            if (!any_o && req_i[cidx]) begin
                any_o       = 1'b1;
                gnt_o[cidx] = 1'b1;
                idx_o       = cidx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing the UART TX FIFO write port
// between several byte requesters, with idle-timeout grant revocation.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned LAST_ON_NL = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    uart_tx_arbiter_if.slave  bus
);

    localparam int unsigned      IDX_W    = idx_width(NUM_REQ);
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_REQ - 1);

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDX_W-1:0]   gidx_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    logic               locked;
    logic               valid_g;
    logic               last_g;
    logic [7:0]         data_g;
    logic               transfer;
    logic               eom;
    logic               tmo;
    logic [IDX_W-1:0]   ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i (bus.req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Reset gates the handshake so nothing is accepted or written on a reset cycle.
    always_comb begin
        locked   = (state_q == ST_LOCKED);
        valid_g  = bus.req_valid_i[gidx_q];
        last_g   = bus.req_last_i[gidx_q];
        data_g   = bus.req_data_i[gidx_q];
        transfer = rst_ni && locked && valid_g && !bus.tx_full_i;
        eom      = transfer && (last_g || ((LAST_ON_NL != 0) && (data_g == NL_BYTE)));
        tmo      = rst_ni && locked && !valid_g && !bus.tx_full_i && (cnt_q == CNT_LAST);
        ptr_next = (gidx_q == IDX_MAX) ? '0 : gidx_q + 1'b1;
    end

    assign bus.req_ready_o = (rst_ni && locked && !bus.tx_full_i) ? grant_q : '0;
    assign bus.tx_we_o     = transfer;
    assign bus.tx_data_o   = locked ? data_g : 8'h00;
    assign bus.grant_o     = grant_q;
    assign bus.busy_o      = locked;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        state_q <= ST_LOCKED;
                        grant_q <= arb_gnt;
                        gidx_q  <= arb_idx;
                        cnt_q   <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (eom || tmo) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        ptr_q   <= ptr_next;
                        cnt_q   <= '0;
                    end else if (transfer) begin
                        cnt_q <= '0;
                    end else if (!valid_g && !bus.tx_full_i) begin
                        // A full FIFO freezes the idle count so back-pressure never revokes.
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench: DUT a (TIMEOUT=8, newline ends message),
// DUT b (TIMEOUT=16, newline is plain data).
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    int unsigned nvec;
    int unsigned nerr;
    int unsigned idx0;
    int unsigned idx2;
    logic [7:0]  b0;
    logic [7:0]  b2;
    logic        v0;
    logic        v2;
    logic        l0;
    logic        l2;

    logic       exp_we [14] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0};
    logic [7:0] exp_d  [14] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h20,
                                8'h21, 8'h22, 8'h23, 8'h00, 8'h30, 8'h31, 8'h00};
    logic [3:0] exp_g  [14] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4,
                                4'h4, 4'h4, 4'h4, 4'h0, 4'h1, 4'h1, 4'h0};

    uart_tx_arbiter_if #(.NUM_REQ(4)) if_a ();
    uart_tx_arbiter_if #(.NUM_REQ(4)) if_b ();

    uart_tx_arbiter #(
        .NUM_REQ    (4),
        .TIMEOUT    (8),
        .LAST_ON_NL (1)
    ) u_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if_a)
    );

    uart_tx_arbiter #(
        .NUM_REQ    (4),
        .TIMEOUT    (16),
        .LAST_ON_NL (0)
    ) u_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                         input logic f);
        if_a.req_valid_i = v;
        if_a.req_last_i  = l;
        if_a.req_data_i  = d;
        if_a.tx_full_i   = f;
    endtask

    task automatic drv_b(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                         input logic f);
        if_b.req_valid_i = v;
        if_b.req_last_i  = l;
        if_b.req_data_i  = d;
        if_b.tx_full_i   = f;
    endtask

    task automatic chk_a(input string tag, input logic we, input logic [7:0] d,
                         input logic [3:0] g, input logic b);
        check({tag, "_a_we"},    32'(if_a.tx_we_o),   32'(we));
        check({tag, "_a_data"},  32'(if_a.tx_data_o), 32'(d));
        check({tag, "_a_grant"}, 32'(if_a.grant_o),   32'(g));
        check({tag, "_a_busy"},  32'(if_a.busy_o),    32'(b));
    endtask

    task automatic chk_b(input string tag, input logic we, input logic [7:0] d,
                         input logic [3:0] g, input logic b);
        check({tag, "_b_we"},    32'(if_b.tx_we_o),   32'(we));
        check({tag, "_b_data"},  32'(if_b.tx_data_o), 32'(d));
        check({tag, "_b_grant"}, 32'(if_b.grant_o),   32'(g));
        check({tag, "_b_busy"},  32'(if_b.busy_o),    32'(b));
    endtask

    initial begin
        nvec  = 0;
        nerr  = 0;
        rst_n = 1'b0;
        drv_a(4'b0000, 4'b0000, 32'h0, 1'b0);
        drv_b(4'b0000, 4'b0000, 32'h0, 1'b0);
        tick();
        tick();
        chk_a("rst", 1'b0, 8'h00, 4'h0, 1'b0);
        chk_b("rst", 1'b0, 8'h00, 4'h0, 1'b0);
        check("rst_a_ready", 32'(if_a.req_ready_o), 32'h0);

        // Single message "OK\n" from requester 1, released by the newline.
        tick(); rst_n = 1'b1;
        drv_a(4'b0010, 4'b0000, 32'h0000_4F00, 1'b0); #1;
        chk_a("t1_idle", 1'b0, 8'h00, 4'h0, 1'b0);
        tick(); #1;
        chk_a("t1_b0", 1'b1, 8'h4F, 4'b0010, 1'b1);
        check("t1_ready", 32'(if_a.req_ready_o), 32'h2);
        tick(); drv_a(4'b0010, 4'b0000, 32'h0000_4B00, 1'b0); #1;
        chk_a("t1_b1", 1'b1, 8'h4B, 4'b0010, 1'b1);
        tick(); drv_a(4'b0010, 4'b0000, 32'h0000_0A00, 1'b0); #1;
        chk_a("t1_b2", 1'b1, 8'h0A, 4'b0010, 1'b1);
        tick(); drv_a(4'b1101, 4'b1101, 32'hC3B2_00A0, 1'b0); #1;
        chk_a("t1_dead", 1'b0, 8'h00, 4'h0, 1'b0);
        tick(); #1;
        chk_a("rr_p2", 1'b1, 8'hB2, 4'b0100, 1'b1);
        tick(); drv_a(4'b1001, 4'b1001, 32'hC3B2_00A0, 1'b0); #1;
        chk_a("rr_dead1", 1'b0, 8'h00, 4'h0, 1'b0);
        tick(); #1;
        chk_a("rr_p3", 1'b1, 8'hC3, 4'b1000, 1'b1);
        tick(); drv_a(4'b0001, 4'b0001, 32'hC3B2_00A0, 1'b0); #1;
        chk_a("rr_dead2", 1'b0, 8'h00, 4'h0, 1'b0);
        tick(); #1;
        chk_a("rr_wrap0", 1'b1, 8'hA0, 4'b0001, 1'b1);
        tick(); drv_a(4'b0000, 4'b0000, 32'h0, 1'b0); #1;
        chk_a("rr_idle", 1'b0, 8'h00, 4'h0, 1'b0);

        // Contention from reset: requesters 0 and 2, then a late second message from 0.
        tick(); rst_n = 1'b0; #1;
        idx0 = 0;
        idx2 = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            rst_n = 1'b1;
            v0 = (idx0 < 6) && (idx0 != 4 || c >= 7);
            b0 = (idx0 < 4) ? 8'(8'h10 + idx0) : (idx0 < 6) ? 8'(8'h30 + idx0 - 4) : 8'h00;
            l0 = (idx0 == 3) || (idx0 == 5);
            v2 = (idx2 < 4);
            b2 = v2 ? 8'(8'h20 + idx2) : 8'h00;
            l2 = (idx2 == 3);
            drv_a({1'b0, v2, 1'b0, v0}, {1'b0, l2, 1'b0, l0}, {8'h00, b2, 8'h00, b0}, 1'b0);
            #1;
            check($sformatf("ct%0d_we", c),    32'(if_a.tx_we_o),   32'(exp_we[c]));
            check($sformatf("ct%0d_data", c),  32'(if_a.tx_data_o), 32'(exp_d[c]));
            check($sformatf("ct%0d_grant", c), 32'(if_a.grant_o),   32'(exp_g[c]));
            if (if_a.req_valid_i[0] && if_a.req_ready_o[0]) idx0++;
            if (if_a.req_valid_i[2] && if_a.req_ready_o[2]) idx2++;
        end

        // Idle timeout: requester 3 sends one byte then goes quiet while 0 waits.
        tick(); drv_a(4'b1000, 4'b0000, 32'h5500_0000, 1'b0); #1;
        chk_a("to_idle", 1'b0, 8'h00, 4'h0, 1'b0);
        tick(); drv_a(4'b1001, 4'b0001, 32'h5500_0066, 1'b0); #1;
        chk_a("to_xfer", 1'b1, 8'h55, 4'b1000, 1'b1);
        check("to_ready", 32'(if_a.req_ready_o), 32'h8);
        for (int i = 0; i < 8; i++) begin
            tick(); drv_a(4'b0001, 4'b0001, 32'h0000_0066, 1'b0); #1;
            chk_a($sformatf("to_wait%0d", i), 1'b0, 8'h00, 4'b1000, 1'b1);
        end
        tick(); #1;
        chk_a("to_rel", 1'b0, 8'h00, 4'h0, 1'b0);
        tick(); #1;
        chk_a("to_next", 1'b1, 8'h66, 4'b0001, 1'b1);
        tick(); drv_a(4'b0000, 4'b0000, 32'h0, 1'b0); #1;
        chk_a("to_end", 1'b0, 8'h00, 4'h0, 1'b0);

        // Reset asserted mid-message.
        tick(); drv_a(4'b0010, 4'b0000, 32'h0000_7700, 1'b0); #1;
        chk_a("rm_idle", 1'b0, 8'h00, 4'h0, 1'b0);
        tick(); #1;
        chk_a("rm_xfer", 1'b1, 8'h77, 4'b0010, 1'b1);
        tick(); rst_n = 1'b0; drv_a(4'b0010, 4'b0000, 32'h0000_7800, 1'b0); #1;
        check("rm_rst_we", 32'(if_a.tx_we_o), 32'h0);
        check("rm_rst_ready", 32'(if_a.req_ready_o), 32'h0);
        tick(); rst_n = 1'b1; drv_a(4'b0000, 4'b0000, 32'h0, 1'b0); #1;
        chk_a("rm_after", 1'b0, 8'h00, 4'h0, 1'b0);
        check("rm_after_ready", 32'(if_a.req_ready_o), 32'h0);

        // Back-pressure on DUT b: 50 full cycles mid-message, longer than TIMEOUT.
        tick(); drv_b(4'b0100, 4'b0000, 32'h0041_0000, 1'b0); #1;
        chk_b("bp_idle", 1'b0, 8'h00, 4'h0, 1'b0);
        tick(); #1;
        chk_b("bp_b0", 1'b1, 8'h41, 4'b0100, 1'b1);
        for (int i = 0; i < 50; i++) begin
            tick(); drv_b(4'b0100, 4'b0000, 32'h0042_0000, 1'b1); #1;
            chk_b($sformatf("bp_full%0d", i), 1'b0, 8'h42, 4'b0100, 1'b1);
            check($sformatf("bp_full%0d_ready", i), 32'(if_b.req_ready_o), 32'h0);
        end
        tick(); drv_b(4'b0100, 4'b0000, 32'h0042_0000, 1'b0); #1;
        chk_b("bp_resume", 1'b1, 8'h42, 4'b0100, 1'b1);
        tick(); drv_b(4'b0100, 4'b0100, 32'h0043_0000, 1'b0); #1;
        chk_b("bp_last", 1'b1, 8'h43, 4'b0100, 1'b1);
        tick(); drv_b(4'b0000, 4'b0000, 32'h0, 1'b0); #1;
        chk_b("bp_end", 1'b0, 8'h00, 4'h0, 1'b0);

        // DUT b: newline without last keeps the grant; last releases it.
        tick(); drv_b(4'b0010, 4'b0000, 32'h0000_0A00, 1'b0); #1;
        chk_b("nl_idle", 1'b0, 8'h00, 4'h0, 1'b0);
        tick(); #1;
        chk_b("nl_b0", 1'b1, 8'h0A, 4'b0010, 1'b1);
        tick(); drv_b(4'b0010, 4'b0010, 32'h0000_2100, 1'b0); #1;
        chk_b("nl_hold", 1'b1, 8'h21, 4'b0010, 1'b1);
        tick(); drv_b(4'b0000, 4'b0000, 32'h0, 1'b0); #1;
        chk_b("nl_rel", 1'b0, 8'h00, 4'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
